seg7_scan_decoder: RTL

Receive-side monitor for the active-low 8-digit seven-segment bus (segments/an). It samples the multiplexed digit-enable and segment lines, filters out scan transitions and ghosting, and decodes each stable glyph back into a 4-bit hex value per digit position. It sits on the display pins as a self-check and loopback reader for the hex display encoder.

---
 rtl/seg7_scan_decoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Loopback reader for the active-low 8-digit seven-segment bus: filters scan transitions
// and decodes each stable glyph to hex per digit. SEG7_SCAN_DEC_DP_EN enables dp capture.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  segments,
  input  logic [7:0]  an,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [7:0]  dp_out,
  output logic        upd_pulse,
  output logic [2:0]  upd_idx,
  output logic        code_err
);

  typedef enum logic [1:0] {StIdle, StCount, StCapture, StLocked} state_e;

  localparam logic [7:0] StableTarget = 8'(STABLE_CYCLES);

  logic [7:0] seg_s1_q, seg_s2_q, an_s1_q, an_s2_q;
  logic [7:0] pair_seg_q, pair_an_q;
  logic [7:0] cnt_q;
  state_e     state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= 8'hFF;
      seg_s2_q <= 8'hFF;
      an_s1_q  <= 8'hFF;
      an_s2_q  <= 8'hFF;
    end else begin
      seg_s1_q <= segments;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  logic       pair_changed;
  logic [7:0] cnt_inc;

  assign pair_changed = (seg_s2_q != pair_seg_q) || (an_s2_q != pair_an_q);
  assign cnt_inc      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  logic [3:0] low_cnt;
  logic [2:0] sel_idx;
  logic       single_sel;

  always_comb begin
    low_cnt = 4'd0;
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!pair_an_q[i]) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = 3'(i);
      end
    end
    single_sel = (low_cnt == 4'd1);
  end

  // The dp bit never takes part in glyph recognition.
  logic [7:0] glyph;
  logic [3:0] hex_val;
  logic       is_hex;
  logic       is_blank;

  always_comb begin
    glyph   = pair_seg_q | 8'h80;
    hex_val = 4'h0;
    is_hex  = 1'b1;
    case (glyph)
      8'hC0: hex_val = 4'h0;
      8'hF9: hex_val = 4'h1;
      8'hA4: hex_val = 4'h2;
      8'hB0: hex_val = 4'h3;
      8'h99: hex_val = 4'h4;
      8'h92: hex_val = 4'h5;
      8'h82: hex_val = 4'h6;
      8'hF8: hex_val = 4'h7;
      8'h80: hex_val = 4'h8;
      8'h90: hex_val = 4'h9;
      8'h88: hex_val = 4'hA;
      8'h83: hex_val = 4'hB;
      8'hA7: hex_val = 4'hC;
      8'hA1: hex_val = 4'hD;
      8'h86: hex_val = 4'hE;
      8'h8E: hex_val = 4'hF;
      default: is_hex = 1'b0;
    endcase
    is_blank = (glyph == 8'hFF);
  end

`ifdef SEG7_SCAN_DEC_DP_EN
  logic [7:0] dp_q;
  assign dp_out = dp_q;
`else
  assign dp_out = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      pair_seg_q  <= 8'hFF;
      pair_an_q   <= 8'hFF;
      digits      <= 32'h0;
      digit_valid <= 8'h00;
      upd_pulse   <= 1'b0;
      upd_idx     <= 3'd0;
      code_err    <= 1'b0;
`ifdef SEG7_SCAN_DEC_DP_EN
      dp_q        <= 8'h00;
`endif
    end else begin
      upd_pulse <= 1'b0;
      if (err_clr) code_err <= 1'b0;
      unique case (state_q)
        StIdle, StLocked: begin
          if (pair_changed) begin
            pair_seg_q <= seg_s2_q;
            pair_an_q  <= an_s2_q;
            cnt_q      <= 8'd1;
            state_q    <= StCount;
          end
        end
        StCount: begin
          if (pair_changed) begin
            pair_seg_q <= seg_s2_q;
            pair_an_q  <= an_s2_q;
            cnt_q      <= 8'd1;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= StableTarget) begin
              if (single_sel) begin
                // Outputs are written on the edge that raises upd_pulse.
                state_q   <= StCapture;
                upd_pulse <= 1'b1;
                upd_idx   <= sel_idx;
                if (is_hex) begin
                  digits[{sel_idx, 2'b00} +: 4] <= hex_val;
                  digit_valid[sel_idx]          <= 1'b1;
`ifdef SEG7_SCAN_DEC_DP_EN
                  dp_q[sel_idx]                 <= ~pair_seg_q[7];
`endif
                end else begin
                  digit_valid[sel_idx] <= 1'b0;
                  if (!is_blank) code_err <= 1'b1;
                end
              end else begin
                state_q <= StLocked;
              end
            end
          end
        end
        StCapture: state_q <= StLocked;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule
